// File: rtl/alu_exec_pkg.sv
// Shared opcode constants, FSM encoding and opcode classification helpers.
package alu_exec_pkg;

  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_LSH  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_ADDU = 4'b0110;
  localparam logic [3:0] OP_ADDC = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_SUBC = 4'b1010;
  localparam logic [3:0] OP_CMP  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // True for every opcode the ALU implements.
  function automatic logic op_is_defined(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_LSH, OP_ADD, OP_ADDU,
      OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/exec_regfile.sv
// Register array: two operand read ports, one debug read port, one write port.
module exec_regfile #(
  parameter int unsigned REG_WIDTH     = 16,
  parameter int unsigned REG_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [REG_ADDR_BITS-1:0] waddr_i,
  input  logic [REG_WIDTH-1:0]     wdata_i,
  input  logic [REG_ADDR_BITS-1:0] raddr_a_i,
  output logic [REG_WIDTH-1:0]     rdata_a_o,
  input  logic [REG_ADDR_BITS-1:0] raddr_b_i,
  output logic [REG_WIDTH-1:0]     rdata_b_o,
  input  logic [REG_ADDR_BITS-1:0] dbg_addr_i,
  output logic [REG_WIDTH-1:0]     dbg_data_o
);

  localparam int unsigned NUM_REGS = 1 << REG_ADDR_BITS;

  logic [REG_WIDTH-1:0] regs_q [NUM_REGS];

  // Single write port; async clear of the whole array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the pre-write value during a write cycle.
  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU: IDLE -> READ -> EXEC -> WB, with direct load and debug read.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int unsigned REG_WIDTH     = 16,
  parameter int unsigned REG_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3:0]               aluOpCode,
  input  logic [REG_ADDR_BITS-1:0] regAddressA,
  input  logic [REG_ADDR_BITS-1:0] regAddressB,
  input  logic                     loadEnable,
  input  logic [REG_ADDR_BITS-1:0] loadAddress,
  input  logic [REG_WIDTH-1:0]     loadData,
  input  logic [REG_ADDR_BITS-1:0] dbgAddress,
  output logic [REG_WIDTH-1:0]     dbgData,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [REG_WIDTH-1:0]     aluResult,
  output logic                     carryFlag,
  output logic                     lowFlag,
  output logic                     overflowFlag,
  output logic                     negFlag,
  output logic                     zeroFlag
);

  localparam int unsigned MSB = REG_WIDTH - 1;
  localparam int unsigned EW  = REG_WIDTH + 1;

  state_e                   state_q, state_d;
  logic [3:0]               op_q;
  logic [REG_ADDR_BITS-1:0] addr_a_q, addr_b_q;
  logic [REG_WIDTH-1:0]     opa_q, opb_q;
  logic [REG_WIDTH-1:0]     result_q, result_d;
  logic                     c_q, l_q, f_q, n_q, z_q;
  logic                     c_d, l_d, f_d, n_d, z_d;
  logic                     done_q, error_q;
  logic [REG_WIDTH-1:0]     rd_a, rd_b;
  logic                     load_we, wb_we, rf_we;
  logic [REG_ADDR_BITS-1:0] rf_waddr;
  logic [REG_WIDTH-1:0]     rf_wdata;
  logic                     cin, bin;
  logic [REG_WIDTH:0]       sum_w, diff_w;
  logic                     add_ovf, sub_ovf;
  logic [REG_WIDTH-1:0]     shamt, shift_res;

  // Next-state sequencing; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture the command at start and the operands in READ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        op_q     <= aluOpCode;
        addr_a_q <= regAddressA;
        addr_b_q <= regAddressB;
      end
      if (state_q == ST_READ) begin
        opa_q <= rd_a;
        opb_q <= rd_b;
      end
    end
  end

  // Datapath primitives shared by the opcode decode below.
  assign cin       = (op_q == OP_ADDC) ? c_q : 1'b0;
  assign bin       = (op_q == OP_SUBC) ? c_q : 1'b0;
  assign sum_w     = {1'b0, opa_q} + {1'b0, opb_q} + EW'(cin);
  assign diff_w    = {1'b0, opa_q} - {1'b0, opb_q} - EW'(bin);
  assign add_ovf   = (opa_q[MSB] == opb_q[MSB]) && (sum_w[MSB] != opa_q[MSB]);
  assign sub_ovf   = (opa_q[MSB] != opb_q[MSB]) && (diff_w[MSB] != opa_q[MSB]);
  assign shamt     = opb_q[MSB] ? (~opb_q + REG_WIDTH'(1)) : opb_q;
  assign shift_res = (shamt >= REG_WIDTH'(REG_WIDTH)) ? '0 :
                     (opb_q[MSB] ? (opa_q >> shamt) : (opa_q << shamt));

  // Result and flag update in EXEC; undefined opcodes leave everything as is.
  always_comb begin
    result_d = result_q;
    c_d = c_q;
    l_d = l_q;
    f_d = f_q;
    n_d = n_q;
    z_d = z_q;
    if (state_q == ST_EXEC) begin
      case (op_q)
        OP_AND: result_d = opa_q & opb_q;
        OP_OR:  result_d = opa_q | opb_q;
        OP_XOR: result_d = opa_q ^ opb_q;
        OP_LSH: result_d = shift_res;
        OP_ADD, OP_ADDU, OP_ADDC: begin
          result_d = sum_w[MSB:0];
          c_d      = sum_w[REG_WIDTH];
          l_d      = opa_q < opb_q;
          f_d      = add_ovf;
        end
        OP_SUB, OP_SUBC, OP_CMP: begin
          result_d = diff_w[MSB:0];
          c_d      = diff_w[REG_WIDTH];
          l_d      = opa_q < opb_q;
          f_d      = sub_ovf;
        end
        default: result_d = result_q;
      endcase
      if (op_is_defined(op_q)) begin
        n_d = result_d[MSB];
        z_d = (result_d == '0);
      end
    end
  end

  // Result, flags and the one-cycle status pulses following WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      c_q      <= 1'b0;
      l_q      <= 1'b0;
      f_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      c_q      <= c_d;
      l_q      <= l_d;
      f_q      <= f_d;
      n_q      <= n_d;
      z_q      <= z_d;
      done_q   <= (state_q == ST_WB);
      error_q  <= (state_q == ST_WB) && !op_is_defined(op_q);
    end
  end

  // Write port shared by WB and the direct load (which only fires in IDLE).
  assign load_we  = (state_q == ST_IDLE) && loadEnable && !start;
  assign wb_we    = (state_q == ST_WB) && op_is_defined(op_q) && (op_q != OP_CMP);
  assign rf_we    = load_we || wb_we;
  assign rf_waddr = wb_we ? addr_a_q : loadAddress;
  assign rf_wdata = wb_we ? result_q : loadData;

  exec_regfile #(
    .REG_WIDTH    (REG_WIDTH),
    .REG_ADDR_BITS(REG_ADDR_BITS)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (addr_a_q),
    .rdata_a_o (rd_a),
    .raddr_b_i (addr_b_q),
    .rdata_b_o (rd_b),
    .dbg_addr_i(dbgAddress),
    .dbg_data_o(dbgData)
  );

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign error        = error_q;
  assign aluResult    = result_q;
  assign carryFlag    = c_q;
  assign lowFlag      = l_q;
  assign overflowFlag = f_q;
  assign negFlag      = n_q;
  assign zeroFlag     = z_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized scoreboard bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int W    = 16;
  localparam int NR   = 16;
  localparam int MASK = 'hFFFF;

  localparam int C_AND = 1, C_OR = 2, C_XOR = 3, C_LSH = 4, C_ADD = 5, C_ADDU = 6;
  localparam int C_ADDC = 7, C_SUB = 9, C_SUBC = 10, C_CMP = 11;

  logic        clk, reset, start, loadEnable;
  logic [3:0]  aluOpCode, regAddressA, regAddressB, loadAddress, dbgAddress;
  logic [15:0] loadData, dbgData, aluResult;
  logic        busy, done, error;
  logic        carryFlag, lowFlag, overflowFlag, negFlag, zeroFlag;

  alu_exec_unit #(.REG_WIDTH(16), .REG_ADDR_BITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .aluOpCode(aluOpCode),
    .regAddressA(regAddressA), .regAddressB(regAddressB),
    .loadEnable(loadEnable), .loadAddress(loadAddress), .loadData(loadData),
    .dbgAddress(dbgAddress), .dbgData(dbgData),
    .busy(busy), .done(done), .error(error), .aluResult(aluResult),
    .carryFlag(carryFlag), .lowFlag(lowFlag), .overflowFlag(overflowFlag),
    .negFlag(negFlag), .zeroFlag(zeroFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit       err;
    bit [4:0] flg;
    int       dval;
    int       scyc;
    int       dest;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_pass = 0, n_total = 0, n_done_seen = 0, n_expected = 0;

  // Reference architectural state.
  int mreg[NR];
  bit mc, ml, mf, mn, mz;

  function automatic int sgn(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Apply one operation to the reference state.
  task automatic model_run(input int op, input int ra, input int rb, output bit err);
    int a, b, r, s, sa, sh;
    bit cin, wr;
    a = mreg[ra]; b = mreg[rb]; r = 0; err = 1'b0; wr = 1'b1;
    case (op)
      C_AND: r = a & b;
      C_OR:  r = a | b;
      C_XOR: r = a ^ b;
      C_LSH: begin
        sh = sgn(b);
        if (sh >= 0) r = (sh >= W) ? 0 : ((a << sh) & MASK);
        else         r = (-sh >= W) ? 0 : (a >> (-sh));
      end
      C_ADD, C_ADDU, C_ADDC: begin
        cin = (op == C_ADDC) ? mc : 1'b0;
        s = a + b + int'(cin); sa = sgn(a) + sgn(b) + int'(cin);
        r = s & MASK; mc = (s > MASK); ml = (a < b); mf = (sa > 32767) || (sa < -32768);
      end
      C_SUB, C_SUBC, C_CMP: begin
        cin = (op == C_SUBC) ? mc : 1'b0;
        s = a - b - int'(cin); sa = sgn(a) - sgn(b) - int'(cin);
        r = s & MASK; mc = (s < 0); ml = (a < b); mf = (sa > 32767) || (sa < -32768);
        if (op == C_CMP) wr = 1'b0;
      end
      default: err = 1'b1;
    endcase
    if (!err) begin
      mn = ((r >> 15) & 1) == 1;
      mz = (r == 0);
      if (wr) mreg[ra] = r;
    end
  endtask

  task automatic do_load(input int addr, input int data);
    @(negedge clk);
    loadEnable = 1'b1; loadAddress = 4'(addr); loadData = 16'(data);
    @(negedge clk);
    loadEnable = 1'b0;
    mreg[addr] = data & MASK;
  endtask

  // Issue one op; optionally poke start/load while busy or collide a load with start.
  task automatic do_op(input int op, input int ra, input int rb, input bit poke, input bit coll);
    exp_t e;
    bit   err;
    int   old;
    @(negedge clk);
    old = mreg[ra];
    model_run(op, ra, rb, err);
    e.err = err; e.flg = {mc, ml, mf, mn, mz}; e.dval = mreg[ra]; e.scyc = cyc; e.dest = ra;
    sbq.push_back(e);
    n_expected++;
    dbgAddress = 4'(ra); aluOpCode = 4'(op); regAddressA = 4'(ra); regAddressB = 4'(rb);
    start = 1'b1;
    if (coll) begin
      loadEnable = 1'b1; loadAddress = 4'(ra); loadData = 16'($urandom);
    end
    @(negedge clk);
    start = poke; loadEnable = poke;
    if (poke) begin
      aluOpCode = 4'($urandom); regAddressA = 4'($urandom); regAddressB = 4'($urandom);
      loadAddress = 4'(ra); loadData = 16'($urandom);
    end
    @(negedge clk);
    @(negedge clk);
    chk("dbg_old_during_wb", int'(dbgData), old);
    start = 1'b0; loadEnable = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic scan_regs(input string name);
    for (int i = 0; i < NR; i++) begin
      dbgAddress = 4'(i);
      #1;
      chk(name, int'(dbgData), mreg[i]);
    end
  endtask

  // Monitor: pop and compare whenever the DUT reports completion.
  always @(negedge clk) begin
    #1;
    if (reset && (done || error)) begin
      chk("done_with_error", int'(done), 1);
      if (done) begin
        n_done_seen++;
        chk("sb_nonempty_at_done", int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          mon_e = sbq.pop_front();
          chk("error", int'(error), int'(mon_e.err));
          chk("flags_CLFNZ", int'({carryFlag, lowFlag, overflowFlag, negFlag, zeroFlag}),
              int'(mon_e.flg));
          chk("dest_value", int'(dbgData), mon_e.dval);
          chk("done_latency", cyc - mon_e.scyc, 4);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int op, ra, rb;
    bit err;
    reset = 1'b0; start = 1'b0; loadEnable = 1'b0; aluOpCode = '0;
    regAddressA = '0; regAddressB = '0; loadAddress = '0; loadData = '0; dbgAddress = '0;
    for (int i = 0; i < NR; i++) mreg[i] = 0;
    {mc, ml, mf, mn, mz} = '0;

    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_result", int'(aluResult), 0);
    chk("reset_flags", int'({carryFlag, lowFlag, overflowFlag, negFlag, zeroFlag}), 0);
    scan_regs("reset_regs");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Add with carry-out, then add-with-carry consuming it.
    do_load(1, 'h0001); do_load(2, 'hFFFF);
    do_op(C_ADDU, 2, 1, 1'b0, 1'b0);
    chk("addu_r2", int'(dbgData), 'h0000);
    chk("addu_C", int'(carryFlag), 1);
    chk("addu_Z", int'(zeroFlag), 1);
    do_op(C_ADDC, 1, 1, 1'b0, 1'b0);
    chk("addc_r1", int'(dbgData), 'h0003);
    chk("addc_C", int'(carryFlag), 0);
    chk("addc_Z", int'(zeroFlag), 0);

    // Borrowing subtract and a compare that must not write back.
    do_load(0, 'h0000); do_load(1, 'h0001);
    do_op(C_SUB, 0, 1, 1'b0, 1'b0);
    chk("sub_r0", int'(dbgData), 'hFFFF);
    chk("sub_LNC", int'({lowFlag, negFlag, carryFlag}), 'b111);
    do_op(C_CMP, 1, 1, 1'b0, 1'b0);
    chk("cmp_Z", int'(zeroFlag), 1);
    chk("cmp_r1", int'(dbgData), 'h0001);

    // Signed overflow, then a right shift via negative shift amount.
    do_load(3, 'h7FFF);
    do_op(C_ADD, 3, 1, 1'b0, 1'b0);
    chk("add_r3", int'(dbgData), 'h8000);
    chk("add_FN", int'({overflowFlag, negFlag}), 'b11);
    do_load(4, 'hFFFF);
    do_op(C_LSH, 3, 4, 1'b0, 1'b0);
    chk("lsh_r3", int'(dbgData), 'h4000);

    // Undefined opcode with start/load poked while busy; start/load collision.
    do_op(15, 2, 3, 1'b1, 1'b0);
    do_op(C_AND, 5, 6, 1'b0, 1'b1);
    scan_regs("directed_regs");

    // Randomized mix of loads and operations.
    repeat (80) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, MASK)));
      end else begin
        op = int'($urandom_range(0, 15));
        ra = int'($urandom_range(0, NR - 1));
        rb = int'($urandom_range(0, NR - 1));
        do_op(op, ra, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      end
    end
    scan_regs("random_regs");

    // Reset during EXEC aborts the op: no done, no writeback, everything cleared.
    do_load(7, 'h1234); do_load(8, 'h0101);
    @(negedge clk);
    dbgAddress = 4'd7; aluOpCode = 4'(C_ADD); regAddressA = 4'd7; regAddressB = 4'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(aluResult), 0);
    chk("abort_flags", int'({carryFlag, lowFlag, overflowFlag, negFlag, zeroFlag}), 0);
    chk("abort_r7", int'(dbgData), 0);
    for (int i = 0; i < NR; i++) mreg[i] = 0;
    {mc, ml, mf, mn, mz} = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    scan_regs("post_abort_regs");
    do_op(C_SUB, 9, 10, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    chk("done_count", n_done_seen, n_expected);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter REG_WIDTH, default 16, SHALL set the datapath and register width.
REQ-002 Parameter REG_ADDR_BITS, default 4, SHALL set the register count to 2**REG_ADDR_BITS.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on the rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  in  1  SHALL request one operation; sampled only in IDLE.
REQ-006 aluOpCode  in  4  SHALL give the operation, captured with start.
REQ-007 regAddressA / regAddressB  in  REG_ADDR_BITS each  SHALL give the operand registers; A is also the destination.
REQ-008 loadEnable, loadAddress, loadData  in  1/REG_ADDR_BITS/REG_WIDTH  SHALL form the direct register-load port.
REQ-009 dbgAddress  in  REG_ADDR_BITS; dbgData  out  REG_WIDTH  SHALL form the combinational register read-back port.
REQ-010 busy, done, error  out  1 each  SHALL give status; done and error are one-cycle pulses.
REQ-011 aluResult  out  REG_WIDTH  SHALL hold the last computed result.
REQ-012 carryFlag, lowFlag, overflowFlag, negFlag, zeroFlag  out  1 each  SHALL be the registered flags.

Function
REQ-013 FSM states SHALL be IDLE -> READ -> EXEC -> WB -> IDLE, one clock each; busy=1 outside IDLE.
REQ-014 start in IDLE SHALL capture opcode and addresses; start outside IDLE SHALL be ignored.
REQ-015 READ SHALL latch both operands; EXEC SHALL latch aluResult and flags; WB SHALL write aluResult to register A.
REQ-016 done SHALL pulse in the first IDLE cycle after WB (four edges after the start edge).
REQ-017 Opcodes: AND 0001, OR 0010, XOR 0011, LSH 0100, ADD 0101, ADDU 0110, ADDC 0111, SUB 1001, SUBC 1010, CMP 1011.
REQ-018 Result SHALL equal A op B modulo 2**REG_WIDTH; ADDC adds carryFlag, SUBC subtracts carryFlag as borrow.
REQ-019 LSH SHALL shift A left by B when B is non-negative, logically right by |B| when negative; magnitude >= REG_WIDTH yields 0.
REQ-020 CMP SHALL compute A-B for flags only and SHALL NOT write back.
REQ-021 Arithmetic ops and CMP SHALL update all flags: C = carry/borrow out, L = A<B unsigned, F = signed overflow, N = result MSB, Z = result==0.
REQ-022 Logic ops and LSH SHALL update only N and Z; C, L and F hold.
REQ-023 Undefined opcodes SHALL pulse error with done, perform no writeback and leave flags unchanged.
REQ-024 loadEnable in IDLE without start SHALL write loadData at loadAddress; when loadEnable and start coincide, start wins and the load is dropped; loadEnable outside IDLE is ignored.
REQ-025 A WB write and a dbgData read of the same address in the same cycle SHALL return the old value.

Reset
REQ-026 reset low SHALL immediately force IDLE, clear all registers, aluResult and flags to 0, and deassert busy, done and error.
REQ-027 reset mid-operation SHALL abort with no writeback and no done pulse.

Structure
REQ-028 Opcode constants and FSM state encodings SHALL live in the shared package alu_exec_pkg.
REQ-029 The register array, with two read ports, a debug read port and one write port, SHALL be the sub-module exec_regfile; the ALU datapath stays in alu_exec_unit.

Verification
REQ-030 Load r1=0001, r2=FFFF; ADDU A=2,B=1 -> r2=0000, C=1, Z=1, done four edges after start.
REQ-031 Then ADDC A=1,B=1 with C=1 -> r1=0003, C=0, Z=0.
REQ-032 r0=0000, r1=0001; SUB A=0,B=1 -> r0=FFFF, L=1, N=1, C=1 (borrow); CMP A=1,B=1 -> Z=1, r1 unchanged.
REQ-033 r3=7FFF, r1=0001; ADD A=3,B=1 -> r3=8000, F=1, N=1; LSH r3 by FFFF -> 4000.
REQ-034 Opcode 1111 -> error and done pulse, registers and flags unchanged; start asserted while busy -> ignored.
REQ-035 reset low during EXEC -> immediate IDLE, all registers 0, no done pulse, no writeback.
